mem_bus_arbiter: RTL
====================

// Module: mem_bus_arbiter
// PURPOSE
//  Owns the external memory port and shares it between the CPU and a DMA requester.
//  CPU side: decoder control (w_rd, pc_data) plus PC and data-bus addresses.
//  Runs one access at a time through a setup/wait/complete sequence with a
//  programmable wait-state count and a ready timeout.
//  Drives cpu_stall so the decoder holds its micro-step counter until cpu_ack.
// PARAMETERS
//  ADDR_W       16  address width
//  DATA_W       8   data width
//  WAIT_STATES  1   minimum ACCESS cycles before mem_ready is honoured (0 allowed)
//  TIMEOUT      15  extra cycles to wait for mem_ready before bus error (>=1)
// PORTS
//  clk            in   1       single system clock, all state on posedge
//  rst            in   1       asynchronous, active-low reset
//  cpu_req        in   1       CPU access request; held until cpu_ack
//  cpu_w_rd       in   1       1=write, 0=read
//  cpu_pc_data    in   1       1=address from cpu_pc_addr, 0=from cpu_data_addr
//  cpu_pc_addr    in   ADDR_W  program counter address
//  cpu_data_addr  in   ADDR_W  data-bus address
//  cpu_wdata      in   DATA_W  CPU write data
//  cpu_rdata      out  DATA_W  registered read data, valid with cpu_ack
//  cpu_ack        out  1       one-cycle completion pulse
//  cpu_stall      out  1       comb: cpu_req & ~(CPU transaction completing this cycle)
//  dma_req        in   1       DMA request; held until dma_ack
//  dma_w_rd       in   1       1=write, 0=read
//  dma_addr       in   ADDR_W  DMA address
//  dma_wdata      in   DATA_W  DMA write data
//  dma_rdata      out  DATA_W  registered read data, valid with dma_ack
//  dma_ack        out  1       one-cycle completion pulse
//  mem_en         out  1       external access active
//  mem_w_rd       out  1       external write(1)/read(0)
//  mem_addr       out  ADDR_W  external address
//  mem_wdata      out  DATA_W  external write data
//  mem_rdata      in   DATA_W  external read data
//  mem_ready      in   1       external device ready
//  bus_err        out  1       one-cycle pulse alongside ack when the access timed out
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE; mem_en, mem_w_rd, cpu_ack, dma_ack, bus_err = 0;
//    mem_addr, mem_wdata, cpu_rdata, dma_rdata = 0; rr pointer = CPU.
//  - Reset mid-access aborts immediately: mem_en drops, no ack is issued.
//  - FSM: IDLE -> SETUP -> ACCESS -> DONE -> IDLE.
//  - IDLE: if any req, select winner and latch w_rd, address, wdata and owner.
//    CPU address = cpu_pc_data ? cpu_pc_addr : cpu_data_addr. Next state: SETUP.
//  - SETUP: mem_en=1; latched values on mem_*; wait counter <= WAIT_STATES; next ACCESS.
//  - ACCESS: mem_en=1; counter decrements to 0.
//    When counter==0 and mem_ready=1: latch mem_rdata (reads only), go DONE.
//    After counter==0, mem_ready low for TIMEOUT cycles: go DONE with error flag.
//  - DONE: mem_en=0. Owner's ack=1 for exactly one cycle.
//    Read: owner rdata holds captured data; timed-out read returns all-ones.
//    Timed-out access also raises bus_err=1. Writes leave rdata unchanged. Next IDLE.
//  - Latency with immediate ready: request sampled in IDLE -> ack WAIT_STATES+3 cycles later.
//  - Requester inputs may change after IDLE latches them; they have no effect.
//    Requester must drop req in the cycle after ack; req still high in IDLE is a new request.
//  - req dropped mid-transaction: access still completes and ack still pulses.
//  - Back-to-back: an IDLE cycle always separates transactions; mem_en is low in DONE and IDLE.
//  - Both requests in the same IDLE cycle: priority per CONFIGURATION; loser waits
//    (cpu_stall stays 1 if the CPU loses).
// CONFIGURATION
//  ARB_ROUND_ROBIN_EN defined:
//    - Pointer flips to the other requester after each granted transaction.
//    - On simultaneous requests the pointer's owner wins.
//    - A single requester always wins.
//  ARB_ROUND_ROBIN_EN undefined: fixed priority, CPU always wins over DMA.
// TESTING
//  1. WAIT_STATES=1, mem_ready=1; CPU read, pc_data=1, pc_addr=16'h8000, mem_rdata=8'h69
//     -> mem_addr=16'h8000, mem_w_rd=0, cpu_ack 4 cycles after req sampled, cpu_rdata=8'h69.
//  2. CPU write pc_data=0, data_addr=16'h0200, wdata=8'hA5 -> mem_w_rd=1, mem_wdata=8'hA5
//     through SETUP/ACCESS, cpu_ack pulse, cpu_rdata unchanged, dma_ack stays 0.
//  3. cpu_req and dma_req both rise the same cycle, 4 transactions:
//     undefined macro -> CPU,CPU,CPU,CPU; defined -> CPU,DMA,CPU,DMA.
//  4. mem_ready held 0, TIMEOUT=15, DMA read -> ack and bus_err together 16 cycles after
//     ACCESS counter hits 0; dma_rdata=8'hFF.
//  5. Assert rst=0 during ACCESS -> mem_en=0 and all outputs at reset values same cycle;
//     no ack after release; next request completes normally.
//  6. WAIT_STATES=0, mem_ready=1, DMA read 16'h1234 -> dma_ack 3 cycles after sample;
//     cpu_stall=1 for a CPU request raised during it.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Shares the external memory port between the CPU and a DMA requester, one access at a time.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; by default the CPU has fixed priority.
module mem_bus_arbiter #(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned TIMEOUT     = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_w_rd,
    input  logic              cpu_pc_data,
    input  logic [ADDR_W-1:0] cpu_pc_addr,
    input  logic [ADDR_W-1:0] cpu_data_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_stall,
    input  logic              dma_req,
    input  logic              dma_w_rd,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_ack,
    output logic              mem_en,
    output logic              mem_w_rd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              bus_err
);

    localparam int unsigned WCNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam int unsigned TCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WCNT_W-1:0] WAIT_INIT = WCNT_W'(WAIT_STATES);
    localparam logic [TCNT_W-1:0] TCNT_MAX  = TCNT_W'(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess, StDone} state_e;

    state_e              state_q, state_d;
    logic                owner_cpu_q, owner_cpu_d;
    logic                w_rd_q, w_rd_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0]   dma_rdata_q, dma_rdata_d;
    logic                grant_cpu;

`ifdef ARB_ROUND_ROBIN_EN
    // rr_cpu_q set means the CPU wins the next simultaneous request
    logic rr_cpu_q, rr_cpu_d;
    assign grant_cpu = cpu_req & (~dma_req | rr_cpu_q);
`else
    assign grant_cpu = cpu_req;
`endif

    always_comb begin
        state_d     = state_q;
        owner_cpu_d = owner_cpu_q;
        w_rd_d      = w_rd_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wcnt_d      = wcnt_q;
        tcnt_d      = tcnt_q;
        err_d       = err_q;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;
`ifdef ARB_ROUND_ROBIN_EN
        rr_cpu_d    = rr_cpu_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (cpu_req | dma_req) begin
                    owner_cpu_d = grant_cpu;
                    if (grant_cpu) begin
                        w_rd_d  = cpu_w_rd;
                        addr_d  = cpu_pc_data ? cpu_pc_addr : cpu_data_addr;
                        wdata_d = cpu_wdata;
                    end else begin
                        w_rd_d  = dma_w_rd;
                        addr_d  = dma_addr;
                        wdata_d = dma_wdata;
                    end
`ifdef ARB_ROUND_ROBIN_EN
                    rr_cpu_d = ~grant_cpu;
`endif
                    state_d = StSetup;
                end
            end
            StSetup: begin
                wcnt_d  = WAIT_INIT;
                tcnt_d  = '0;
                err_d   = 1'b0;
                state_d = StAccess;
            end
            StAccess: begin
                if (wcnt_q != '0) begin
                    wcnt_d = wcnt_q - 1'b1;
                end else if (mem_ready) begin
                    if (!w_rd_q) begin
                        if (owner_cpu_q) cpu_rdata_d = mem_rdata;
                        else             dma_rdata_d = mem_rdata;
                    end
                    state_d = StDone;
                end else if (tcnt_q == TCNT_MAX) begin
                    // Timed-out reads hand back all-ones so the requester sees a defined value
                    err_d = 1'b1;
                    if (!w_rd_q) begin
                        if (owner_cpu_q) cpu_rdata_d = '1;
                        else             dma_rdata_d = '1;
                    end
                    state_d = StDone;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            owner_cpu_q <= 1'b1;
            w_rd_q      <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wcnt_q      <= '0;
            tcnt_q      <= '0;
            err_q       <= 1'b0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            rr_cpu_q    <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            owner_cpu_q <= owner_cpu_d;
            w_rd_q      <= w_rd_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wcnt_q      <= wcnt_d;
            tcnt_q      <= tcnt_d;
            err_q       <= err_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
`ifdef ARB_ROUND_ROBIN_EN
            rr_cpu_q    <= rr_cpu_d;
`endif
        end
    end

    assign mem_en    = (state_q == StSetup) || (state_q == StAccess);
    assign mem_w_rd  = w_rd_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign cpu_ack   = (state_q == StDone) && owner_cpu_q;
    assign dma_ack   = (state_q == StDone) && !owner_cpu_q;
    assign bus_err   = (state_q == StDone) && err_q;
    assign cpu_rdata = cpu_rdata_q;
    assign dma_rdata = dma_rdata_q;
    assign cpu_stall = cpu_req & ~cpu_ack;

endmodule
